// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit ALU datapath (READ_A/READ_B/EXEC/WRITE/DONE).
// Optional retired-instruction counter on perf_count when ALU_SEQ_PERF_EN is defined.
module alu_seq_ctrl #(
  parameter int RN_W   = 3,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        instr_op,
  input  logic [RN_W-1:0]   instr_rd,
  input  logic [RN_W-1:0]   instr_rn,
  input  logic [RN_W-1:0]   instr_rm,
  input  logic              instr_wb,
  input  logic              status_in,
  output logic [RN_W-1:0]   rf_rd_num,
  output logic [RN_W-1:0]   rf_wr_num,
  output logic              rf_write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              done,
`ifdef ALU_SEQ_PERF_EN
  output logic [PERF_W-1:0] perf_count,
`endif
  output logic              z_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op, w_op_nxt;
  logic [RN_W-1:0]   r_rd, r_rn, r_rm, w_rd_nxt, w_rn_nxt, w_rm_nxt;
  logic              r_wb, w_wb_nxt;

  logic [RN_W-1:0]   r_rf_rd_num, r_rf_wr_num, w_rf_rd_num, w_rf_wr_num;
  logic              r_rf_write, r_loada, r_loadb, r_loadc, r_busy, r_done, r_z_flag;
  logic              w_rf_write, w_loada, w_loadb, w_loadc, w_busy, w_done;
  logic [1:0]        r_alu_op, w_alu_op;

  // Next state and instruction latch; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_rd_nxt    = r_rd;
    w_rn_nxt    = r_rn;
    w_rm_nxt    = r_rm;
    w_wb_nxt    = r_wb;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ_A;
          w_op_nxt    = instr_op;
          w_rd_nxt    = instr_rd;
          w_rn_nxt    = instr_rn;
          w_rm_nxt    = instr_rm;
          w_wb_nxt    = instr_wb;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ_A: w_state_nxt = (r_op == 2'b11) ? S_EXEC : S_READ_B;
      S_READ_B: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = r_wb ? S_WRITE : S_DONE;
      S_WRITE:  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so the registered copies are Moore-aligned.
  always_comb begin
    w_rf_rd_num = {RN_W{1'b0}};
    w_rf_wr_num = {RN_W{1'b0}};
    w_rf_write  = 1'b0;
    w_loada     = 1'b0;
    w_loadb     = 1'b0;
    w_loadc     = 1'b0;
    w_alu_op    = 2'b00;
    w_done      = 1'b0;
    w_busy      = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_IDLE:   w_busy = 1'b0;
      S_READ_A: begin
        w_rf_rd_num = w_rn_nxt;
        w_loada     = 1'b1;
      end
      S_READ_B: begin
        w_rf_rd_num = w_rm_nxt;
        w_loadb     = 1'b1;
      end
      S_EXEC: begin
        w_alu_op = w_op_nxt;
        w_loadc  = 1'b1;
      end
      S_WRITE: begin
        w_rf_write  = 1'b1;
        w_rf_wr_num = w_rd_nxt;
        w_alu_op    = w_op_nxt;
      end
      S_DONE:   w_done = 1'b1;
      default:  w_busy = 1'b0;
    endcase
  end

  // State, instruction latch, registered outputs and zero flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_rd        <= {RN_W{1'b0}};
      r_rn        <= {RN_W{1'b0}};
      r_rm        <= {RN_W{1'b0}};
      r_wb        <= 1'b0;
      r_rf_rd_num <= {RN_W{1'b0}};
      r_rf_wr_num <= {RN_W{1'b0}};
      r_rf_write  <= 1'b0;
      r_loada     <= 1'b0;
      r_loadb     <= 1'b0;
      r_loadc     <= 1'b0;
      r_alu_op    <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_z_flag    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_rd        <= w_rd_nxt;
      r_rn        <= w_rn_nxt;
      r_rm        <= w_rm_nxt;
      r_wb        <= w_wb_nxt;
      r_rf_rd_num <= w_rf_rd_num;
      r_rf_wr_num <= w_rf_wr_num;
      r_rf_write  <= w_rf_write;
      r_loada     <= w_loada;
      r_loadb     <= w_loadb;
      r_loadc     <= w_loadc;
      r_alu_op    <= w_alu_op;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_z_flag    <= (r_state == S_EXEC) ? status_in : r_z_flag;
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [PERF_W-1:0] r_perf_count;

  // Retired-instruction counter, wraps naturally at 2**PERF_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_count <= {PERF_W{1'b0}};
    end else if (r_state == S_DONE) begin
      r_perf_count <= r_perf_count + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      r_perf_count <= r_perf_count;
    end
  end

  assign perf_count = r_perf_count;
`endif

  assign rf_rd_num = r_rf_rd_num;
  assign rf_wr_num = r_rf_wr_num;
  assign rf_write  = r_rf_write;
  assign loada     = r_loada;
  assign loadb     = r_loadb;
  assign loadc     = r_loadc;
  assign alu_op    = r_alu_op;
  assign busy      = r_busy;
  assign done      = r_done;
  assign z_flag    = r_z_flag;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl; perf checks need ALU_SEQ_PERF_EN.
module tb_alu_seq_ctrl;
  localparam int RN_W   = 3;
  localparam int PERF_W = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [1:0]      instr_op;
  logic [RN_W-1:0] instr_rd, instr_rn, instr_rm;
  logic            instr_wb;
  logic            status_in;
  logic [RN_W-1:0] rf_rd_num, rf_wr_num;
  logic            rf_write, loada, loadb, loadc, busy, done, z_flag;
  logic [1:0]      alu_op;
`ifdef ALU_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_ctrl #(.RN_W(RN_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rn(instr_rn),
    .instr_rm(instr_rm), .instr_wb(instr_wb), .status_in(status_in),
    .rf_rd_num(rf_rd_num), .rf_wr_num(rf_wr_num), .rf_write(rf_write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .alu_op(alu_op),
    .busy(busy), .done(done),
`ifdef ALU_SEQ_PERF_EN
    .perf_count(perf_count),
`endif
    .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  // Expected output vector: {rd_num, wr_num, rf_write, loada, loadb, loadc, alu_op, busy, done, z_flag}
  function automatic logic [14:0] ev(input logic [2:0] rdn, input logic [2:0] wrn,
                                     input logic wr, input logic la, input logic lb,
                                     input logic lc, input logic [1:0] op,
                                     input logic bz, input logic dn, input logic z);
    return {rdn, wrn, wr, la, lb, lc, op, bz, dn, z};
  endfunction

  function automatic logic [14:0] obs();
    return {rf_rd_num, rf_wr_num, rf_write, loada, loadb, loadc, alu_op, busy, done, z_flag};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] o;
    o = obs();
    n_checks++;
    assert (o === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic step(input string tag, input logic [14:0] exp);
    @(posedge clk); #1;
    chk(tag, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                       input logic [2:0] rd, input logic wb, input logic st);
    instr_op = op; instr_rn = rn; instr_rm = rm; instr_rd = rd; instr_wb = wb;
    status_in = st; start = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; instr_op = 2'b00; instr_rd = 3'd0;
    instr_rn = 3'd0; instr_rm = 3'd0; instr_wb = 1'b0; status_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 15'd0);
`ifdef ALU_SEQ_PERF_EN
    n_checks++;
    assert (perf_count === 2'd0) else begin
      n_errors++; $error("FAIL perf_reset observed=%0d expected=0", perf_count);
    end
`endif
    reset_n = 1'b1;
    step("idle", 15'd0);

    // ADD full: rn=1 rm=2 rd=3
    issue(2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    step("add_c1", ev(3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    step("add_c2", ev(3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("add_c3", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
    step("add_c4", ev(3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("add_c5", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    step("add_c6", 15'd0);

    // Compare: sub, wb=0, zero result
    issue(2'b01, 3'd4, 3'd5, 3'd7, 1'b0, 1'b1);
    step("cmp_c1", ev(3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    step("cmp_c2", ev(3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("cmp_c3", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0));
    step("cmp_c4", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1));
    step("cmp_c5", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));

    // ADD with rn==rm, nonzero result clears z
    issue(2'b00, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0);
    step("add2_c1", ev(3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));
    start = 1'b0;
    step("add2_c2", ev(3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));
    step("add2_c3", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1));
    step("add2_c4", ev(3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("add2_c5", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    step("add2_c6", 15'd0);

    // Pass-A with writeback: rn=5 rd=6
    issue(2'b11, 3'd5, 3'd3, 3'd6, 1'b1, 1'b1);
    step("pass_c1", ev(3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    step("pass_c2", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0));
    step("pass_c3", ev(3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1));
    step("pass_c4", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1));
    step("pass_c5", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));

    // Pass-A compare: shortest path, done in cycle 3
    issue(2'b11, 3'd2, 3'd0, 3'd4, 1'b0, 1'b0);
    step("pcmp_c1", ev(3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));
    start = 1'b0;
    step("pcmp_c2", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1));
    step("pcmp_c3", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    step("pcmp_c4", 15'd0);

    // start held high; instr_* changed while busy must not disturb the running op
    issue(2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    step("b2b_c1", ev(3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    instr_op = 2'b10; instr_rn = 3'd4; instr_rm = 3'd6; instr_rd = 3'd5;
    step("b2b_c2", ev(3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("b2b_c3", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
    step("b2b_c4", ev(3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("b2b_c5", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    step("b2b_c6", 15'd0);
    step("b2b_c7", ev(3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    step("b2b_c8", ev(3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    step("b2b_c9", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0));
    step("b2b_c10", ev(3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
    step("b2b_c11", ev(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    step("b2b_c12", 15'd0);

    // Reset asserted during READ_B, mid-cycle
    issue(2'b00, 3'd7, 3'd6, 3'd1, 1'b1, 1'b1);
    step("rst_c1", ev(3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    step("rst_c2", ev(3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    #2 reset_n = 1'b0;
    #1 chk("rst_async", 15'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step("rst_after", 15'd0);
    issue(2'b11, 3'd3, 3'd0, 3'd3, 1'b0, 1'b0);
    step("rst_restart", ev(3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef ALU_SEQ_PERF_EN
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [PERF_W-1:0] exp_cnt;
      exp_cnt = PERF_W'(i + 1);
      issue(2'b11, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      assert (perf_count === exp_cnt) else begin
        n_errors++;
        $error("FAIL perf_count observed=%0d expected=%0d", perf_count, exp_cnt);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit ALU datapath: register file → A/B operand registers → ALU → result register C → register-file writeback, plus a zero-status flag register.
- Accepts one instruction per start/done handshake.
- Drives all datapath load enables, register-file read/write selects and the ALU op code.
- Sits between the instruction source (test harness or later decoder) and the datapath.

Parameters:
- RN_W, 3, register-number width (2**RN_W registers).
- PERF_W, 16, width of the retired-instruction counter; used only with ALU_SEQ_PERF_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to execute instr; sampled only in IDLE.
- instr_op  input  2  ALU op: 00 add, 01 sub, 10 and, 11 pass A.
- instr_rd  input  RN_W  destination register.
- instr_rn  input  RN_W  operand A register.
- instr_rm  input  RN_W  operand B register.
- instr_wb  input  1  1 = write result to rd; 0 = flags only (compare).
- status_in  input  1  ALU zero output from datapath.
- rf_rd_num  output  RN_W  register-file read select.
- rf_wr_num  output  RN_W  register-file write select.
- rf_write  output  1  register-file write enable.
- loada  output  1  load operand register A.
- loadb  output  1  load operand register B.
- loadc  output  1  load result register C.
- alu_op  output  2  op driven to ALU.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- z_flag  output  1  registered zero flag.
- perf_count  output  PERF_W  retired-instruction count; ALU_SEQ_PERF_EN builds only.

Behaviour:
- Reset: reset_n low asynchronously forces state IDLE. Instruction latch is cleared. All outputs are 0, including z_flag and perf_count.
- Reset mid-operation: the in-flight instruction is discarded, with no write and no done. After release, the block waits in IDLE for a new start.
- Outputs are Moore, decoded from registered state and the latched instruction. They hold their values for the whole cycle.
- States: IDLE, READ_A, READ_B, EXEC, WRITE, DONE.
- IDLE:
  - Outputs 0 except z_flag and perf_count.
  - On an edge with start=1, latch op/rd/rn/rm/wb and go to READ_A.
  - start while busy=1 is ignored and not queued.
- READ_A: rf_rd_num=rn, loada=1. Next state is EXEC if op==11, else READ_B.
- READ_B: rf_rd_num=rm, loadb=1. Next state is EXEC.
- EXEC:
  - alu_op=op, loadc=1.
  - At the closing edge, z_flag <= status_in.
  - Next state is WRITE if wb=1, else DONE.
- WRITE: rf_write=1, rf_wr_num=rd, alu_op held at op. Next state is DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE. A new start is accepted only once back in IDLE.
- alu_op is 00 in all states other than EXEC and WRITE.
- rf_rd_num and rf_wr_num are 0 when not in use.
- Latency, with start sampled at edge 0:
  - Full op: done high in cycle 5.
  - op==11 or wb=0: cycle 4.
  - op==11 and wb=0: cycle 3.
- rd==rn or rd==rm is legal; the operand is already captured before WRITE.
- z_flag changes only at the EXEC edge and holds otherwise, including across wb=0 compares.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- Defined: perf_count increments by 1 on each DONE-state edge. It wraps from 2**PERF_W-1 to 0 and is cleared by reset_n.
- Undefined: perf_count port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-op: reset_n low during READ_B → all outputs 0 immediately (async). After release, no rf_write and no done until the next start.
- ADD full: start with op=00, rn=1, rm=2, rd=3, wb=1 → loada in cycle 1 (rf_rd_num=1), loadb in cycle 2 (rf_rd_num=2), loadc in cycle 3 (alu_op=00), rf_write in cycle 4 (rf_wr_num=3), done in cycle 5.
- Compare: op=01, wb=0, status_in=1 in EXEC → no rf_write, z_flag=1 from cycle 4, done in cycle 4. A following ADD with status_in=0 → z_flag=0.
- Pass-A: op=11, rn=5, rd=6, wb=1 → no loadb cycle, loadc in cycle 2, rf_write to 6 in cycle 3, done in cycle 4.
- Busy start: start held high continuously → new instruction accepted on the edge after DONE, i.e. back-to-back spacing of 6 cycles for full ops. Changing instr_* while busy does not affect the outputs.
- Perf counter (ALU_SEQ_PERF_EN, PERF_W=2): 5 instructions → perf_count = 1, 2, 3, 0, 1.
